// File: rtl/axi_rd_arbiter_n_if.sv
// rtl/axi_rd_arbiter_n_if.sv - request/response and grant bundle for the read-address arbiter
interface axi_rd_arbiter_n_if #(
    parameter int NUM_M  = 3,
    parameter int NUM_S  = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic [NUM_M-1:0]        ARVALID_M;
    logic [NUM_M*ADDR_W-1:0] ARADDR_M;
    logic [NUM_M*LEN_W-1:0]  ARLEN_M;
    logic [NUM_M-1:0]        WPEND_M;
    logic                    AR_READY;
    logic                    R_VALID;
    logic                    R_READY;
    logic                    R_LAST;
    logic                    gnt_valid;
    logic [NUM_M-1:0]        gnt_m;
    logic [NUM_S-1:0]        gnt_s;
    logic                    gnt_decerr;
    logic                    len_err;
    logic                    tmo_err;

    // Requesters and slave-path handshakes drive the arbiter, and they observe the grant.
    modport master (
        output ARVALID_M, ARADDR_M, ARLEN_M, WPEND_M, AR_READY, R_VALID, R_READY, R_LAST,
        input  gnt_valid, gnt_m, gnt_s, gnt_decerr, len_err, tmo_err
    );

    // The arbiter samples requests and handshakes, and it drives the grant.
    modport slave (
        input  ARVALID_M, ARADDR_M, ARLEN_M, WPEND_M, AR_READY, R_VALID, R_READY, R_LAST,
        output gnt_valid, gnt_m, gnt_s, gnt_decerr, len_err, tmo_err
    );
endinterface

// File: rtl/axi_rd_arbiter_n.sv
// rtl/axi_rd_arbiter_n.sv - N-master AXI read-address arbiter with region decode, burst check and watchdog
module axi_rd_arbiter_n #(
    parameter int NUM_M   = 3,
    parameter int NUM_S   = 8,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 4,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 256,
    parameter logic [NUM_S*ADDR_W-1:0] S_BASE = {
        32'h0003_0000, 32'h0010_0000, 32'h2000_0000, 32'h1001_0000,
        32'h1000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] S_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_rd_arbiter_n_if.slave bus
);
    localparam int MW       = $clog2(NUM_M);
    localparam int BW       = LEN_W + 1;
    localparam int TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [MW-1:0]      r_last;
    logic [NUM_M-1:0]   r_gnt_m;
    logic [NUM_S-1:0]   r_gnt_s;
    logic               r_decerr;
    logic [LEN_W-1:0]   r_len;
    logic [BW-1:0]      r_beats;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_len_err;
    logic               r_tmo_err;

    logic [NUM_M-1:0]   w_elig;
    logic               w_any;
    logic [MW-1:0]      w_win_idx;
    logic [NUM_M-1:0]   w_win_oh;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [LEN_W-1:0]   w_win_len;
    logic [NUM_S-1:0]   w_dec_s;
    logic               w_dec_hit;
    logic               w_grant;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_r_last;
    logic               w_progress;
    logic               w_tmo_fire;
    logic [BW-1:0]      w_beats_inc;
    logic [BW-1:0]      w_len_p1;
    logic               w_busy;
    logic [NUM_M-1:0]   w_gnt_m;
    logic [NUM_S-1:0]   w_gnt_s;
    logic               w_decerr;

    // Pick the winner among eligible masters: lowest index, or rotating from the last grant.
    always_comb begin
        int j;
        j         = 0;
        w_elig    = bus.ARVALID_M & ~bus.WPEND_M;
        w_any     = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (RR_MODE != 0) begin
                j = int'(r_last) + k + 1;
                if (j >= NUM_M) j = j - NUM_M;
            end else begin
                j = k;
            end
            if (!w_any && ((w_elig & (NUM_M'(1) << j)) != '0)) begin
                w_any     = 1'b1;
                w_win_idx = MW'(j);
            end
        end
        w_win_oh   = NUM_M'(1) << w_win_idx;
        w_win_addr = ADDR_W'(bus.ARADDR_M >> (int'(w_win_idx) * ADDR_W));
        w_win_len  = LEN_W'(bus.ARLEN_M >> (int'(w_win_idx) * LEN_W));
    end

    // Decode the winner's address; the lowest-numbered matching region takes priority.
    always_comb begin
        w_dec_s   = '0;
        w_dec_hit = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (!w_dec_hit &&
                ((w_win_addr & ADDR_W'(S_MASK >> (i * ADDR_W))) == ADDR_W'(S_BASE >> (i * ADDR_W)))) begin
                w_dec_hit = 1'b1;
                w_dec_s   = NUM_S'(1) << i;
            end
        end
    end

    // Handshake qualifiers, beat arithmetic and watchdog expiry for the current state.
    always_comb begin
        w_grant     = (r_state == S_IDLE) && w_any;
        w_ar_hs     = (r_state == S_ADDR) && bus.AR_READY;
        w_r_hs      = (r_state == S_DATA) && bus.R_VALID && bus.R_READY;
        w_r_last    = w_r_hs && bus.R_LAST;
        w_progress  = w_ar_hs || w_r_hs;
        w_beats_inc = (r_beats == '1) ? r_beats : r_beats + BW'(1);
        w_len_p1    = {1'b0, r_len} + BW'(1);
        w_tmo_fire  = (TIMEOUT > 0) && (r_state != S_IDLE) && !w_progress &&
                      (r_tmo == TMO_W'(TMO_LAST));
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: grant, address handshake, last beat, or watchdog release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_state_nxt = S_ADDR;
            S_ADDR: begin
                if (w_tmo_fire)        w_state_nxt = S_IDLE;
                else if (bus.AR_READY) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tmo_fire || w_r_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the grant on entry to ADDR and track beats, watchdog and error pulses.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_last    <= MW'(NUM_M - 1);
            r_gnt_m   <= '0;
            r_gnt_s   <= '0;
            r_decerr  <= 1'b0;
            r_len     <= '0;
            r_beats   <= '0;
            r_tmo     <= '0;
            r_len_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_len_err <= w_r_last && (w_beats_inc != w_len_p1);
            r_tmo_err <= w_tmo_fire;
            if (w_grant) begin
                r_last   <= w_win_idx;
                r_gnt_m  <= w_win_oh;
                r_gnt_s  <= w_dec_s;
                r_decerr <= !w_dec_hit;
                r_len    <= w_win_len;
                r_beats  <= '0;
                r_tmo    <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_r_hs) r_beats <= w_beats_inc;
                if (w_progress) r_tmo <= '0;
                else            r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    // Grant outputs are only presented while a grant is held.
    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_gnt_m  = w_busy ? r_gnt_m : '0;
        w_gnt_s  = w_busy ? r_gnt_s : '0;
        w_decerr = w_busy && r_decerr;
    end

    assign bus.gnt_valid  = w_busy;
    assign bus.gnt_m      = w_gnt_m;
    assign bus.gnt_s      = w_gnt_s;
    assign bus.gnt_decerr = w_decerr;
    assign bus.len_err    = r_len_err;
    assign bus.tmo_err    = r_tmo_err;
endmodule
